// File: rtl/rsa_pkg.sv
// Shared types for the RSA modular exponentiation block: operand widths and
// the top-level sequencer states.
package rsa_pkg;

  localparam int DEF_WORD_WIDTH = 32;

  typedef logic [DEF_WORD_WIDTH-1:0] word_t;

  // Two guard bits: holds 2*acc + a (< 3*N) without overflow
  typedef logic [DEF_WORD_WIDTH+1:0] wide_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    REDUCE,
    SQUARE,
    MULT,
    FIN
  } state_t;

endpackage

// File: rtl/rsa_modexp_mod_mult.sv
// Bit-serial interleaved modular multiplier: p = a*b mod N, scanning b MSB
// first. Requires a < N; b is unrestricted. done follows start by WIDTH+1 cycles.
module mod_mult import rsa_pkg::*; #(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  input  logic [WORD_WIDTH-1:0] N,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] p
);

  localparam int CW = $clog2(WORD_WIDTH);

  logic [WORD_WIDTH-1:0] aReg, bReg, nReg, acc;
  logic [CW-1:0]         cnt;
  logic                  running;

  logic [WORD_WIDTH+1:0] nWide, doubled, reduced, added;
  logic [WORD_WIDTH-1:0] nextAcc;

  // acc < N keeps every intermediate below 3*N, inside WIDTH+2 bits
  always_comb begin
    nWide   = {2'b00, nReg};
    doubled = {1'b0, acc, 1'b0};
    reduced = (doubled >= nWide) ? (doubled - nWide) : doubled;
    added   = reduced + (bReg[WORD_WIDTH-1] ? {2'b00, aReg} : '0);
    nextAcc = WORD_WIDTH'((added >= nWide) ? (added - nWide) : added);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aReg    <= '0;
      bReg    <= '0;
      nReg    <= '0;
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      aReg    <= a;
      bReg    <= b;
      nReg    <= N;
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b1;
      done    <= 1'b0;
    end else if (running) begin
      acc  <= nextAcc;
      bReg <= bReg << 1;
      cnt  <= cnt + CW'(1);
      if (cnt == CW'(WORD_WIDTH-1)) begin
        running <= 1'b0;
        done    <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign p = acc;

endmodule

// File: rtl/rsa_modexp.sv
// Constant-time left-to-right square-and-multiply: result = msg^exp mod N.
// Every exponent bit costs one square and one multiply regardless of its value.
module rsa_modexp import rsa_pkg::*; #(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] msg,
  input  logic [WORD_WIDTH-1:0] exp,
  input  logic [WORD_WIDTH-1:0] N,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [WORD_WIDTH-1:0] result
);

  localparam int IW = $clog2(WORD_WIDTH);

  state_t state, stateNext;

  logic [WORD_WIDTH-1:0] msgReg, expReg, nReg, acc, base;
  logic [IW-1:0]         bitIdx;
  logic                  opStart;
  logic                  nSmall;

  logic [WORD_WIDTH-1:0] mmA, mmB, mmP;
  logic                  mmDone;

  assign nSmall = (nReg <= WORD_WIDTH'(1));

  // REDUCE computes 1*msg mod N; SQUARE and MULT reuse acc as the a operand
  always_comb begin
    mmA = acc;
    mmB = base;
    if (state == REDUCE) begin
      mmA = WORD_WIDTH'(1);
      mmB = msgReg;
    end else if (state == SQUARE) begin
      mmB = acc;
    end
  end

  mod_mult #(.WORD_WIDTH(WORD_WIDTH)) u_mod_mult (
    .clk   (clk),
    .rst   (rst),
    .start (opStart),
    .a     (mmA),
    .b     (mmB),
    .N     (nReg),
    .done  (mmDone),
    .p     (mmP)
  );

  // opStart fires on the first cycle of each multiplier state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      opStart <= 1'b0;
    end else begin
      state   <= stateNext;
      opStart <= (stateNext != state) &&
                 (stateNext == REDUCE || stateNext == SQUARE || stateNext == MULT);
    end
  end

  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:   if (start) stateNext = CHECK;
      CHECK: begin
        busy      = 1'b1;
        stateNext = nSmall ? FIN : REDUCE;
      end
      REDUCE: begin
        busy = 1'b1;
        if (mmDone) stateNext = SQUARE;
      end
      SQUARE: begin
        busy = 1'b1;
        if (mmDone) stateNext = MULT;
      end
      MULT: begin
        busy = 1'b1;
        if (mmDone) stateNext = (bitIdx == '0) ? FIN : SQUARE;
      end
      FIN: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // The MULT product is always computed; the exponent bit only selects whether it is kept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msgReg <= '0;
      expReg <= '0;
      nReg   <= '0;
      acc    <= '0;
      base   <= '0;
      bitIdx <= '0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          msgReg <= msg;
          expReg <= exp;
          nReg   <= N;
          err    <= 1'b0;
        end
        CHECK: begin
          if (nSmall) begin
            result <= '0;
            err    <= (nReg == '0);
          end else begin
            acc    <= WORD_WIDTH'(1);
            bitIdx <= IW'(WORD_WIDTH-1);
          end
        end
        REDUCE: if (mmDone) base <= mmP;
        SQUARE: if (mmDone) acc <= mmP;
        MULT: if (mmDone) begin
          if (expReg[bitIdx]) acc <= mmP;
          if (bitIdx == '0) result <= expReg[bitIdx] ? mmP : acc;
          else bitIdx <= bitIdx - IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
